// File: rtl/mxint_cast_stream.sv
// rtl/mxint_cast_stream.sv - re-quantises one MXINT block (shared exponent + signed mantissas) to new widths
module mxint_cast_stream #(
  parameter int IN_MAN_WIDTH  = 8,
  parameter int IN_EXP_WIDTH  = 8,
  parameter int OUT_MAN_WIDTH = 8,
  parameter int OUT_EXP_WIDTH = 8,
  parameter int BLOCK_SIZE    = 16,
  parameter int PARALLELISM   = 4,
  parameter int ROUND_MODE    = 0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic signed [IN_MAN_WIDTH-1:0]  mdata_in [PARALLELISM],
  input  logic        [IN_EXP_WIDTH-1:0]  edata_in,
  input  logic                            data_in_valid,
  output logic                            data_in_ready,
  output logic signed [OUT_MAN_WIDTH-1:0] mdata_out [PARALLELISM],
  output logic        [OUT_EXP_WIDTH-1:0] edata_out,
  output logic                            data_out_last,
  output logic                            sat_out,
  output logic                            data_out_valid,
  input  logic                            data_out_ready
);

  localparam int NUM_BEATS = BLOCK_SIZE / PARALLELISM;
  localparam int BW        = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam int EBIAS_IN  = 2**(IN_EXP_WIDTH-1) - 1;
  localparam int EBIAS_OUT = 2**(OUT_EXP_WIDTH-1) - 1;
  localparam int EMAX_OUT  = 2**OUT_EXP_WIDTH - 1;
  localparam int WW        = IN_MAN_WIDTH + OUT_MAN_WIDTH + 2;
  localparam int MAXO      = 2**(OUT_MAN_WIDTH-1) - 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(NUM_BEATS - 1);

  typedef enum logic [1:0] {FILL, CALC, DRAIN} state_t;

  state_t                     state_q, state_d;
  logic [BW-1:0]              beat_q, beat_d;
  logic [IN_MAN_WIDTH-1:0]    max_q, max_d;
  logic [IN_EXP_WIDTH-1:0]    exp_q, exp_d;
  logic                       en_q, en_d;
  logic signed [IN_MAN_WIDTH-1:0]  in_buf_q  [NUM_BEATS][PARALLELISM];
  logic signed [IN_MAN_WIDTH-1:0]  in_buf_d  [NUM_BEATS][PARALLELISM];
  logic signed [OUT_MAN_WIDTH-1:0] out_buf_q [NUM_BEATS][PARALLELISM];
  logic signed [OUT_MAN_WIDTH-1:0] out_buf_d [NUM_BEATS][PARALLELISM];
  logic [OUT_EXP_WIDTH-1:0]   edata_q, edata_d;
  logic                       sat_q, sat_d;

  int                              calc_l, calc_efull, calc_eclamp, calc_shift;
  logic signed [OUT_MAN_WIDTH-1:0] calc_man [NUM_BEATS][PARALLELISM];
  logic                            calc_sat;
  logic [OUT_MAN_WIDTH:0]          cast_r;
  logic [IN_MAN_WIDTH-1:0]         abs_v;

  // Returns {saturated, m * 2^sh} with shifts clamped to where the result no longer changes.
  function automatic logic [OUT_MAN_WIDTH:0] cast_elem(input logic signed [IN_MAN_WIDTH-1:0] m,
                                                       input int sh);
    logic signed [WW-1:0] ext, v, lim;
    logic [WW-1:0]        mag, half;
    int                   amt;
    logic                 sat;
    ext  = {{(WW-IN_MAN_WIDTH){m[IN_MAN_WIDTH-1]}}, m};
    lim  = WW'(MAXO);
    v    = '0;
    mag  = '0;
    half = '0;
    sat  = 1'b0;
    amt  = 0;
    if (m == '0) begin
      v = '0;
    end else if (sh >= 0) begin
      amt = (sh > OUT_MAN_WIDTH + 1) ? OUT_MAN_WIDTH + 1 : sh;
      v   = ext <<< amt;
    end else begin
      amt = (-sh > IN_MAN_WIDTH + 1) ? IN_MAN_WIDTH + 1 : -sh;
      if (ROUND_MODE == 0) begin
        v = ext >>> amt;
      end else begin
        mag  = ext[WW-1] ? -ext : ext;
        half = WW'(1) << (amt - 1);
        mag  = (mag + half) >> amt;
        v    = ext[WW-1] ? -$signed(mag) : $signed(mag);
      end
    end
    if (v > lim) begin
      v   = lim;
      sat = 1'b1;
    end else if (v < -lim) begin
      v   = -lim;
      sat = 1'b1;
    end
    return {sat, v[OUT_MAN_WIDTH-1:0]};
  endfunction

  always_comb begin
    calc_l = 0;
    for (int i = 0; i < IN_MAN_WIDTH; i++) begin
      if (max_q[i]) calc_l = i;
    end
    calc_efull = int'(exp_q) - EBIAS_IN + EBIAS_OUT + calc_l - (IN_MAN_WIDTH - 2);
    if (max_q == '0 || calc_efull < 0) calc_eclamp = 0;
    else if (calc_efull > EMAX_OUT)    calc_eclamp = EMAX_OUT;
    else                               calc_eclamp = calc_efull;
    // Exponent clamping is folded back into the mantissa shift.
    calc_shift = (OUT_MAN_WIDTH - 2) - calc_l + (calc_efull - calc_eclamp);
    calc_sat   = 1'b0;
    cast_r     = '0;
    for (int b = 0; b < NUM_BEATS; b++) begin
      for (int p = 0; p < PARALLELISM; p++) begin
        cast_r         = cast_elem(in_buf_q[b][p], calc_shift);
        calc_man[b][p] = cast_r[OUT_MAN_WIDTH-1:0];
        calc_sat       = calc_sat | cast_r[OUT_MAN_WIDTH];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    max_d     = max_q;
    exp_d     = exp_q;
    en_d      = 1'b1;
    in_buf_d  = in_buf_q;
    out_buf_d = out_buf_q;
    edata_d   = edata_q;
    sat_d     = sat_q;
    abs_v     = '0;
    case (state_q)
      FILL: begin
        if (data_in_valid && en_q) begin
          if (beat_q == '0) begin
            exp_d = edata_in;
            max_d = '0;
          end
          for (int p = 0; p < PARALLELISM; p++) begin
            in_buf_d[beat_q][p] = mdata_in[p];
            abs_v = mdata_in[p][IN_MAN_WIDTH-1] ? -mdata_in[p] : mdata_in[p];
            if (abs_v > max_d) max_d = abs_v;
          end
          if (beat_q == LAST_BEAT) begin
            beat_d  = '0;
            state_d = CALC;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      CALC: begin
        out_buf_d = calc_man;
        edata_d   = OUT_EXP_WIDTH'(calc_eclamp);
        sat_d     = calc_sat;
        state_d   = DRAIN;
      end
      DRAIN: begin
        if (data_out_ready) begin
          if (beat_q == LAST_BEAT) begin
            beat_d  = '0;
            max_d   = '0;
            state_d = FILL;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= FILL;
      beat_q    <= '0;
      max_q     <= '0;
      exp_q     <= '0;
      en_q      <= 1'b0;
      in_buf_q  <= '{default: '0};
      out_buf_q <= '{default: '0};
      edata_q   <= '0;
      sat_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      max_q     <= max_d;
      exp_q     <= exp_d;
      en_q      <= en_d;
      in_buf_q  <= in_buf_d;
      out_buf_q <= out_buf_d;
      edata_q   <= edata_d;
      sat_q     <= sat_d;
    end
  end

  // Outputs are gated by DRAIN so reset forces them low without waiting for a clock.
  always_comb begin
    data_in_ready  = (state_q == FILL) && en_q;
    data_out_valid = (state_q == DRAIN);
    data_out_last  = data_out_valid && (beat_q == LAST_BEAT);
    sat_out        = data_out_valid && sat_q;
    edata_out      = data_out_valid ? edata_q : '0;
    for (int p = 0; p < PARALLELISM; p++) begin
      mdata_out[p] = data_out_valid ? out_buf_q[beat_q][p] : '0;
    end
  end

endmodule

// File: tb/tb_mxint_cast_stream.sv
// tb/tb_mxint_cast_stream.sv - directed bench for mxint_cast_stream, floor and round instances side by side
module tb_mxint_cast_stream;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic signed [7:0] mdata_in [4];
  logic [7:0]        edata_in;
  logic              data_in_valid;
  logic              data_out_ready;

  logic              rdy0, rdy1, v0, v1, last0, last1, sat0, sat1;
  logic signed [3:0] m0_out [4];
  logic signed [3:0] m1_out [4];
  logic [7:0]        e0, e1;

  int checks = 0;
  int errors = 0;

  logic signed [7:0] stim [8];
  int                exp0 [8];
  int                exp1 [8];
  logic signed [7:0] bp_in  [16];
  int                bp_exp [16];

  always #5 clk = ~clk;

  mxint_cast_stream #(.IN_MAN_WIDTH(8), .IN_EXP_WIDTH(8), .OUT_MAN_WIDTH(4), .OUT_EXP_WIDTH(8),
                      .BLOCK_SIZE(8), .PARALLELISM(4), .ROUND_MODE(0)) dut0 (
    .clk(clk), .rst(rst), .mdata_in(mdata_in), .edata_in(edata_in),
    .data_in_valid(data_in_valid), .data_in_ready(rdy0),
    .mdata_out(m0_out), .edata_out(e0), .data_out_last(last0), .sat_out(sat0),
    .data_out_valid(v0), .data_out_ready(data_out_ready)
  );

  mxint_cast_stream #(.IN_MAN_WIDTH(8), .IN_EXP_WIDTH(8), .OUT_MAN_WIDTH(4), .OUT_EXP_WIDTH(8),
                      .BLOCK_SIZE(8), .PARALLELISM(4), .ROUND_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .mdata_in(mdata_in), .edata_in(edata_in),
    .data_in_valid(data_in_valid), .data_in_ready(rdy1),
    .mdata_out(m1_out), .edata_out(e1), .data_out_last(last1), .sat_out(sat1),
    .data_out_valid(v1), .data_out_ready(data_out_ready)
  );

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic send_block(input logic [7:0] e);
    int n;
    for (int b = 0; b < 2; b++) begin
      data_in_valid = 1'b1;
      edata_in      = e;
      for (int p = 0; p < 4; p++) mdata_in[p] = stim[b*4+p];
      n = 0;
      while (!rdy0 && n < 20) begin
        @(posedge clk); #1;
        n++;
      end
      chk("in_ready", rdy0, 1);
      chk("in_ready_match", rdy1, rdy0);
      @(posedge clk); #1;
    end
    data_in_valid = 1'b0;
  endtask

  task automatic recv_block(input int e_exp, input int s0, input int s1);
    int n;
    data_out_ready = 1'b1;
    for (int b = 0; b < 2; b++) begin
      n = 0;
      while (!v0 && n < 20) begin
        @(posedge clk); #1;
        n++;
      end
      chk("out_valid", v0, 1);
      chk("out_valid_r", v1, 1);
      for (int p = 0; p < 4; p++) begin
        chk($sformatf("m_floor_b%0d_e%0d", b, p), m0_out[p], exp0[b*4+p]);
        chk($sformatf("m_round_b%0d_e%0d", b, p), m1_out[p], exp1[b*4+p]);
      end
      chk("edata_floor", e0, e_exp);
      chk("edata_round", e1, e_exp);
      chk("last", last0, (b == 1));
      chk("sat_floor", sat0, s0);
      chk("sat_round", sat1, s1);
      @(posedge clk); #1;
    end
    data_out_ready = 1'b0;
  endtask

  initial begin
    int in_idx, out_idx, n;
    logic take_in;
    data_in_valid  = 1'b0;
    data_out_ready = 1'b0;
    edata_in       = '0;
    for (int p = 0; p < 4; p++) mdata_in[p] = '0;

    // reset values
    #2;
    chk("rst_ready", rdy0, 0);
    chk("rst_valid", v0, 0);
    chk("rst_last", last0, 0);
    chk("rst_sat", sat0, 0);
    chk("rst_edata", e0, 0);
    chk("rst_mdata", m0_out[0], 0);
    #10 rst = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_rst", rdy0, 1);

    // nominal: all 64 at bias exponent
    for (int i = 0; i < 8; i++) begin stim[i] = 8'sd64; exp0[i] = 4; exp1[i] = 4; end
    send_block(8'd127);
    chk("calc_gap_valid", v0, 0);
    chk("calc_gap_ready", rdy0, 0);
    @(posedge clk); #1;
    chk("latency_valid", v0, 1);
    chk("drain_ready", rdy0, 0);
    recv_block(127, 0, 0);
    chk("ready_after_drain", rdy0, 1);
    chk("valid_after_drain", v0, 0);

    // rounding: 120 -> 7.5, -72 -> -4.5
    stim = '{8'sd120, 8'sd64, -8'sd72, -8'sd72, -8'sd72, -8'sd72, -8'sd72, -8'sd72};
    exp0 = '{7, 4, -5, -5, -5, -5, -5, -5};
    exp1 = '{7, 4, -5, -5, -5, -5, -5, -5};
    send_block(8'd127);
    recv_block(127, 0, 1);

    // underflow to zero exponent
    stim = '{8'sd1, 8'sd0, 8'sd1, 8'sd0, 8'sd0, 8'sd1, 8'sd0, 8'sd0};
    exp0 = '{0, 0, 0, 0, 0, 0, 0, 0};
    exp1 = '{0, 0, 0, 0, 0, 0, 0, 0};
    send_block(8'd0);
    recv_block(0, 0, 0);

    // all-zero block
    stim = '{8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0};
    send_block(8'd200);
    recv_block(0, 0, 0);

    // exponent overflow clamp with -128
    stim = '{-8'sd128, 8'sd16, 8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0};
    exp0 = '{-7, 1, 0, 0, 0, 0, 0, 0};
    exp1 = '{-7, 1, 0, 0, 0, 0, 0, 0};
    send_block(8'd255);
    recv_block(255, 1, 1);

    // backpressure: two back-to-back blocks, valid held high, random ready
    bp_in  = '{8'sd16, 8'sd32, 8'sd48, 8'sd64, -8'sd16, -8'sd32, -8'sd48, -8'sd112,
               8'sd64, 8'sd64, 8'sd64, 8'sd64, 8'sd0, 8'sd0, 8'sd0, 8'sd0};
    bp_exp = '{1, 2, 3, 4, -1, -2, -3, -7, 4, 4, 4, 4, 0, 0, 0, 0};
    in_idx  = 0;
    out_idx = 0;
    for (int cyc = 0; cyc < 80 && out_idx < 4; cyc++) begin
      data_in_valid = (in_idx < 4);
      edata_in      = 8'd127;
      if (in_idx < 4) for (int p = 0; p < 4; p++) mdata_in[p] = bp_in[in_idx*4+p];
      data_out_ready = 1'($urandom_range(0, 1));
      take_in = rdy0 && data_in_valid;
      if (v0) begin
        chk("bp_ready_low", rdy0, 0);
        for (int p = 0; p < 4; p++) begin
          chk($sformatf("bp_floor_beat%0d_e%0d", out_idx, p), m0_out[p], bp_exp[out_idx*4+p]);
          chk($sformatf("bp_round_beat%0d_e%0d", out_idx, p), m1_out[p], bp_exp[out_idx*4+p]);
        end
        chk("bp_last", last0, (out_idx % 2 == 1));
        chk("bp_edata", e0, 127);
        if (data_out_ready) out_idx++;
      end
      @(posedge clk); #1;
      if (take_in) in_idx++;
    end
    chk("bp_beats_out", out_idx, 4);
    chk("bp_beats_in", in_idx, 4);
    chk("bp_no_extra", v0, 0);
    data_in_valid  = 1'b0;
    data_out_ready = 1'b0;

    // asynchronous reset mid-drain, after one beat has left
    for (int i = 0; i < 8; i++) stim[i] = 8'sd64;
    send_block(8'd127);
    n = 0;
    while (!v0 && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk("pre_rst_valid", v0, 1);
    data_out_ready = 1'b1;
    @(posedge clk); #1;
    data_out_ready = 1'b0;
    chk("pre_rst_beat1", last0, 1);
    #3 rst = 1'b0;
    #1;
    chk("async_valid", v0, 0);
    chk("async_ready", rdy0, 0);
    chk("async_last", last0, 0);
    chk("async_sat", sat0, 0);
    chk("async_edata", e0, 0);
    chk("async_mdata", m0_out[0], 0);
    #2 rst = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_rst2", rdy0, 1);
    stim = '{8'sd96, 8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd96};
    exp0 = '{6, 0, 0, 0, 0, 0, 0, 6};
    exp1 = '{6, 0, 0, 0, 0, 0, 0, 6};
    send_block(8'd130);
    recv_block(130, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mxint_cast_stream.md
MXINT_CAST_STREAM -- requirements
Module: mxint_cast_stream

Interface
REQ-001 Parameters SHALL be:
- IN_MAN_WIDTH, default 8: input mantissa width, signed.
- IN_EXP_WIDTH, default 8: input exponent width, unsigned, bias 2^(IN_EXP_WIDTH-1)-1.
- OUT_MAN_WIDTH, default 8: output mantissa width, signed.
- OUT_EXP_WIDTH, default 8: output exponent width, bias 2^(OUT_EXP_WIDTH-1)-1.
- BLOCK_SIZE, default 16: elements sharing one exponent.
- PARALLELISM, default 4: elements per beat. BLOCK_SIZE mod PARALLELISM = 0; NUM_BEATS = BLOCK_SIZE/PARALLELISM >= 1.
- ROUND_MODE, default 0: 0 = floor (arithmetic shift), 1 = round half away from zero.

REQ-002 Ports SHALL be:
- clk, in, 1: sole clock; all state on its rising edge.
- rst, in, 1: reset, asynchronous and active-low (0 = reset).
- mdata_in, in, [PARALLELISM] x IN_MAN_WIDTH signed: input mantissas for one beat.
- edata_in, in, IN_EXP_WIDTH: block exponent, sampled on beat 0 only.
- data_in_valid / data_in_ready, in / out, 1: input handshake.
- mdata_out, out, [PARALLELISM] x OUT_MAN_WIDTH signed: output mantissas for one beat.
- edata_out, out, OUT_EXP_WIDTH: block exponent, constant across all beats of a block.
- data_out_last, out, 1: high on the final beat of a block.
- sat_out, out, 1: high on every beat of a block if any element of that block saturated.
- data_out_valid / data_out_ready, out / in, 1: output handshake.

Function
REQ-003 A transfer SHALL occur only on a rising edge with valid and ready both high; valid SHALL NOT depend combinationally on ready.
REQ-004 The FSM SHALL have three states: FILL, CALC and DRAIN.
- FILL: data_in_ready=1, data_out_valid=0.
- CALC: lasts exactly one cycle; both ready and valid are 0.
- DRAIN: data_in_ready=0, data_out_valid=1.
REQ-005 FILL behaviour:
- Each accepted beat SHALL be written to internal buffer slot beat_cnt, and beat_cnt SHALL increment.
- The running max |m| SHALL be updated; |-2^(IN_MAN_WIDTH-1)| is represented exactly.
- edata_in SHALL be latched when beat_cnt=0.
- Acceptance of beat NUM_BEATS-1 SHALL move the FSM to CALC.
REQ-006 CALC SHALL register the following, where E = latched exponent and M = max|m| of the block:
- L = floor(log2 M).
- e_full = E - EBIAS_IN + EBIAS_OUT + L - (IN_MAN_WIDTH-2), evaluated signed with no overflow.
- edata_out = clamp(e_full, 0, 2^OUT_EXP_WIDTH - 1).
- shift = (OUT_MAN_WIDTH-2) - L + (e_full - edata_out).
- CALC SHALL then move to DRAIN.
REQ-007 In DRAIN, beat k SHALL present each element m as follows:
- If m = 0: output 0.
- Otherwise: output m*2^shift, rounded per ROUND_MODE when shift < 0.
- The result SHALL then be saturated to +/-(2^(OUT_MAN_WIDTH-1)-1).
- sat_out SHALL be high if saturation clipped any element of the block; it is computed over the whole block before the first output beat.
REQ-008 If M = 0 (all-zero block), every mdata_out SHALL be 0, edata_out SHALL be 0 and sat_out SHALL be 0.
REQ-009 When data_out_ready=0 in DRAIN, all outputs SHALL be held stable.
REQ-010 When beat NUM_BEATS-1 is accepted in DRAIN, the FSM SHALL return to FILL with beat_cnt=0; data_in_ready SHALL be 1 in the following cycle.
REQ-011 Latency: the first output beat SHALL be valid 2 cycles after the edge that accepted the last input beat (one CALC cycle). Blocks do not overlap.
REQ-012 NUM_BEATS=1 SHALL work, with data_out_last high on every output beat.

Reset
REQ-013 While rst=0, all of the following SHALL hold immediately, regardless of clk:
- FSM = FILL, beat_cnt = 0, running max = 0.
- data_in_ready = 0, data_out_valid = 0, data_out_last = 0, sat_out = 0, edata_out = 0, mdata_out = 0.
REQ-014 On the first clk edge after rst deasserts, data_in_ready SHALL be 1.
REQ-015 A partially filled or partially drained block SHALL be discarded on reset.

Verification
All scenarios use IN_MAN=8, OUT_MAN=4, IN_EXP=OUT_EXP=8, BLOCK_SIZE=8, PARALLELISM=4.
REQ-016 Nominal: two beats of all 64, edata_in=127 -> edata_out=127, mantissas=4, sat_out=0, data_out_last only on the 2nd beat, first valid 2 cycles after the last input.
REQ-017 Rounding: block containing 120 and 64, edata_in=127, with -72 elsewhere:
- ROUND_MODE=0: 120 -> 7 (floor 7.5), -72 -> -5, sat_out=0.
- ROUND_MODE=1: 120 -> 7 (saturated from 8), -72 -> -5, sat_out=1.
REQ-018 Underflow: edata_in=0, max mantissa 1 -> edata_out=0, all mantissas 0. All-zero block with edata_in=200 -> edata_out=0, mantissas 0.
REQ-019 Backpressure: data_out_ready toggled randomly and data_in_valid held high -> no lost or duplicated beats, outputs stable while stalled, data_in_ready=0 throughout DRAIN.
REQ-020 Reset: rst pulled low mid-DRAIN, asynchronously between edges -> data_out_valid drops immediately; the next full input block is processed correctly with no residue from the old block.
